car_motion_ctrl: RTL and testbench

CAR_MOTION_CTRL -- requirements
Module: car_motion_ctrl

---
 rtl/car_pkg.sv | 37 +++
 rtl/dir_lut.sv | 34 +++
 rtl/car_motion_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_car_motion_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared types and constants for the car motion controller.
// Positions are unsigned 9.4 fixed point in map pixels.
package car_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_STEER,
    S_ACCEL,
    S_MOVE,
    S_CLAMP,
    S_COMMIT
  } state_t;

  localparam int POS_INT  = 9;
  localparam int POS_FRAC = 4;
  localparam int POS_W    = POS_INT + POS_FRAC;
  localparam int NXT_W    = 15;
  localparam int SCR_W    = 10;
  localparam int CTR_X    = 160;
  localparam int CTR_Y    = 120;

  typedef struct packed {
    logic left;
    logic right;
    logic gas;
    logic brake;
  } btn_t;

  function automatic logic [SCR_W-1:0] scroll_of(
    input logic [POS_INT-1:0] ip,
    input int                 ctr
  );
    return SCR_W'(ip) - SCR_W'(ctr);
  endfunction

endpackage

// File: rtl/dir_lut.sv
// Heading to unit step in 1/16 pixel, 16 headings clockwise from north.
// dy follows -cos, i.e. the sine table shifted by a quarter turn.
module dir_lut
  import car_pkg::*;
(
  input  logic        [3:0] degree,
  output logic signed [4:0] dx,
  output logic signed [4:0] dy
);

  function automatic logic signed [4:0] sin_of(
    input logic [3:0] d
  );
    logic signed [4:0] m;
    unique case (d[2:0])
      3'd0: m = 5'sd0;
      3'd1: m = 5'sd3;
      3'd2: m = 5'sd6;
      3'd3: m = 5'sd7;
      3'd4: m = 5'sd8;
      3'd5: m = 5'sd7;
      3'd6: m = 5'sd6;
      3'd7: m = 5'sd3;
    endcase
    return d[3] ? -m : m;
  endfunction

  logic [3:0] deg_q;

  assign deg_q = degree + 4'd4;
  assign dx    = sin_of(degree);
  assign dy    = -sin_of(deg_q);

endmodule

// File: rtl/car_motion_ctrl.sv
// Per-frame car motion: steer, accelerate, move and clamp, then
// commit position, heading, speed and scroll on a vsync tick.
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int MAP_WIDTH  = 320,
  parameter int MAP_HEIGHT = 240,
  parameter int START_X    = 160,
  parameter int START_Y    = 200,
  parameter int MAX_SPEED  = 15,
  parameter int ACCEL_DIV  = 4,
  parameter int STEER_DIV  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       run,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_gas,
  input  logic       btn_brake,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic [3:0] degree,
  output logic [3:0] speed,
  output logic       frame_done,
  output logic       busy
);

  localparam int SCW = (STEER_DIV > 1) ? $clog2(STEER_DIV) : 1;
  localparam int ACW = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [SCW-1:0] STEER_LAST = SCW'(STEER_DIV - 1);
  localparam logic [ACW-1:0] ACCEL_LAST = ACW'(ACCEL_DIV - 1);
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
  localparam logic signed [NXT_W-1:0] X_MAX =
    NXT_W'(((MAP_WIDTH - 1) << POS_FRAC) | 15);
  localparam logic signed [NXT_W-1:0] Y_MAX =
    NXT_W'(((MAP_HEIGHT - 1) << POS_FRAC) | 15);
  localparam logic [POS_W-1:0] X0 = POS_W'(START_X << POS_FRAC);
  localparam logic [POS_W-1:0] Y0 = POS_W'(START_Y << POS_FRAC);

  logic [1:0] vs_sync;
  logic       vs_q;
  logic [3:0] b_s1;
  logic [3:0] b_s2;
  logic       tick;

  state_t                   state;
  btn_t                     btn;
  logic [SCW-1:0]           steer_cnt;
  logic [ACW-1:0]           accel_cnt;
  logic [3:0]               deg_w;
  logic [3:0]               spd_w;
  logic [3:0]               steer_step;
  logic [3:0]               spd_nxt;
  logic [POS_W-1:0]         pos_x;
  logic [POS_W-1:0]         pos_y;
  logic [POS_W-1:0]         px_c;
  logic [POS_W-1:0]         py_c;
  logic signed [NXT_W-1:0]  nx;
  logic signed [NXT_W-1:0]  ny;
  logic signed [NXT_W-1:0]  pos_xe;
  logic signed [NXT_W-1:0]  pos_ye;
  logic signed [NXT_W-1:0]  spd_e;
  logic signed [NXT_W-1:0]  dx_e;
  logic signed [NXT_W-1:0]  dy_e;
  logic signed [4:0]        dx;
  logic signed [4:0]        dy;

  function automatic logic [POS_W-1:0] clamp(
    input logic signed [NXT_W-1:0] v,
    input logic signed [NXT_W-1:0] hi
  );
    if (v < 0) return '0;
    if (v > hi) return hi[POS_W-1:0];
    return v[POS_W-1:0];
  endfunction

  dir_lut u_dir (
    .degree (deg_w),
    .dx     (dx),
    .dy     (dy)
  );

  assign tick   = vs_q & ~vs_sync[1];
  assign pos_xe = NXT_W'(pos_x);
  assign pos_ye = NXT_W'(pos_y);
  assign spd_e  = NXT_W'(spd_w);
  assign dx_e   = NXT_W'(dx);
  assign dy_e   = NXT_W'(dy);

  always_comb begin
    steer_step = 4'd0;
    unique case (1'b1)
      btn.left & ~btn.right: steer_step = 4'hf;
      btn.right & ~btn.left: steer_step = 4'h1;
      default:               steer_step = 4'd0;
    endcase
  end

  // Brake wins over gas; coasting bleeds one step.
  always_comb begin
    spd_nxt = speed;
    if (btn.brake)
      spd_nxt = (speed >= 4'd2) ? speed - 4'd2 : 4'd0;
    else if (btn.gas)
      spd_nxt = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'd1;
    else
      spd_nxt = (speed != 4'd0) ? speed - 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sync <= 2'b11;
      vs_q    <= 1'b1;
      b_s1    <= '0;
      b_s2    <= '0;
    end else begin
      vs_sync <= {vs_sync[0], vsync};
      vs_q    <= vs_sync[1];
      b_s1    <= {btn_left, btn_right, btn_gas, btn_brake};
      b_s2    <= b_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      btn        <= '0;
      steer_cnt  <= '0;
      accel_cnt  <= '0;
      deg_w      <= '0;
      spd_w      <= '0;
      nx         <= '0;
      ny         <= '0;
      px_c       <= X0;
      py_c       <= Y0;
      pos_x      <= X0;
      pos_y      <= Y0;
      degree     <= '0;
      speed      <= '0;
      scroll_x   <= scroll_of(X0[POS_W-1:POS_FRAC], CTR_X);
      scroll_y   <= scroll_of(Y0[POS_W-1:POS_FRAC], CTR_Y);
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (run) begin
        unique case (state)
          S_IDLE: begin
            if (tick) begin
              state <= S_SAMPLE;
              busy  <= 1'b1;
            end
          end
          S_SAMPLE: begin
            btn   <= btn_t'(b_s2);
            state <= S_STEER;
          end
          S_STEER: begin
            if (steer_cnt == STEER_LAST) begin
              steer_cnt <= '0;
              deg_w     <= degree + steer_step;
            end else begin
              steer_cnt <= steer_cnt + 1'b1;
              deg_w     <= degree;
            end
            state <= S_ACCEL;
          end
          S_ACCEL: begin
            if (accel_cnt == ACCEL_LAST) begin
              accel_cnt <= '0;
              spd_w     <= spd_nxt;
            end else begin
              accel_cnt <= accel_cnt + 1'b1;
              spd_w     <= speed;
            end
            state <= S_MOVE;
          end
          S_MOVE: begin
            nx    <= pos_xe + spd_e * dx_e;
            ny    <= pos_ye + spd_e * dy_e;
            state <= S_CLAMP;
          end
          S_CLAMP: begin
            px_c  <= clamp(nx, X_MAX);
            py_c  <= clamp(ny, Y_MAX);
            state <= S_COMMIT;
          end
          S_COMMIT: begin
            pos_x      <= px_c;
            pos_y      <= py_c;
            degree     <= deg_w;
            speed      <= spd_w;
            scroll_x   <= scroll_of(px_c[POS_W-1:POS_FRAC], CTR_X);
            scroll_y   <= scroll_of(py_c[POS_W-1:POS_FRAC], CTR_Y);
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: hand table, directed corners and
// random frames against an arithmetic model of the car.
module tb_car_motion_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       vsync = 1'b1;
  logic       run   = 1'b1;
  logic       bl    = 1'b0;
  logic       br    = 1'b0;
  logic       bg    = 1'b0;
  logic       bb    = 1'b0;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic [3:0] degree;
  logic [3:0] speed;
  logic       frame_done;
  logic       busy;

  always #5 clk = ~clk;

  car_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .run        (run),
    .btn_left   (bl),
    .btn_right  (br),
    .btn_gas    (bg),
    .btn_brake  (bb),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .degree     (degree),
    .speed      (speed),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct {
    bit l; bit r; bit g; bit b;
    int deg; int spd;
  } vec_t;

  vec_t tv[12];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mx, my, mdeg, mspd, msc, mac;
  int   sn[16] = '{0, 3, 6, 7, 8, 7, 6, 3,
                   0, -3, -6, -7, -8, -7, -6, -3};
  int   fd_cnt  = 0;
  int   bad     = 0;
  int   fd_long = 0;
  logic [27:0] cur;
  logic [27:0] prev = '0;
  logic        prev_fd = 1'b0;

  assign cur = {scroll_x, scroll_y, degree, speed};

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (frame_done && prev_fd) fd_long <= fd_long + 1;
    prev_fd <= frame_done;
    if (rst && cur != prev && !frame_done) bad <= bad + 1;
    prev <= cur;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void m_reset();
    mx = 160 * 16; my = 200 * 16;
    mdeg = 0; mspd = 0; msc = 0; mac = 0;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void m_step(input bit l, r, g, b);
    if (msc == 2) begin
      msc = 0;
      if (l && !r) mdeg = (mdeg + 15) % 16;
      if (r && !l) mdeg = (mdeg + 1) % 16;
    end else msc++;
    if (mac == 3) begin
      mac = 0;
      if (b) mspd = (mspd > 2) ? mspd - 2 : 0;
      else if (g) mspd = (mspd < 15) ? mspd + 1 : 15;
      else mspd = (mspd > 0) ? mspd - 1 : 0;
    end else mac++;
    mx = clampi(mx + mspd * sn[mdeg], 319 * 16 + 15);
    my = clampi(my - mspd * sn[(mdeg + 4) % 16], 239 * 16 + 15);
  endfunction

  function automatic int m_pack();
    int sx, sy;
    sx = ((mx / 16) - 160) & 1023;
    sy = ((my / 16) - 120) & 1023;
    return (sx << 18) | (sy << 8) | (mdeg << 4) | mspd;
  endfunction

  task automatic frame(input bit l, r, g, b);
    int n;
    @(negedge clk);
    {bl, br, bg, bb} = {l, r, g, b};
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk); n++;
    end
    chk("busy_rise", int'(busy), 1);
    n = 0;
    while (!frame_done && n < 12) begin
      @(negedge clk); n++;
    end
    chk("latency", n, 6);
    m_step(l, r, g, b);
    chk("frame", int'(cur), m_pack());
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int fd0, n;
    bit l, r, g, b;
    tv[0]  = '{0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 15, 0};
    tv[3]  = '{0, 1, 1, 0, 15, 1};
    tv[4]  = '{0, 1, 0, 0, 15, 1};
    tv[5]  = '{0, 1, 0, 0, 0, 1};
    tv[6]  = '{1, 1, 0, 0, 0, 1};
    tv[7]  = '{1, 1, 1, 0, 0, 2};
    tv[8]  = '{1, 1, 0, 0, 0, 2};
    tv[9]  = '{0, 0, 0, 1, 0, 2};
    tv[10] = '{0, 0, 0, 1, 0, 2};
    tv[11] = '{0, 0, 0, 1, 0, 0};

    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_scroll_x", int'(scroll_x), 0);
    chk("rst_scroll_y", int'(scroll_y), 80);
    chk("rst_deg_spd", int'({degree, speed}), 0);
    chk("rst_busy_fd", int'({busy, frame_done}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      frame(tv[i].l, tv[i].r, tv[i].g, tv[i].b);
      chk("tbl_deg", int'(degree), tv[i].deg);
      chk("tbl_spd", int'(speed), tv[i].spd);
    end

    for (int i = 0; i < 64; i++) frame(0, 0, 1, 0);
    chk("gas_sat", int'(speed), 15);
    chk("north_clamp_sy", int'(scroll_y), 904);

    n = 0;
    while (mdeg != 4 && n < 20) begin
      frame(0, 1, 1, 0); n++;
    end
    chk("east_deg", int'(degree), 4);
    for (int i = 0; i < 40; i++) frame(0, 0, 1, 0);
    chk("east_clamp_sx", int'(scroll_x), 159);
    chk("east_sy", int'(scroll_y), 904);

    for (int i = 0; i < 40; i++) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      frame(l, r, g, b);
    end

    // Second falling edge lands in CLAMP and must be ignored.
    fd0 = fd_cnt;
    @(negedge clk);
    {bl, br, bg, bb} = 4'b0010;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk); n++;
    end
    chk("drop_busy", int'(busy), 1);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    n = 0;
    while (!frame_done && n < 12) begin
      @(negedge clk); n++;
    end
    chk("drop_latency", n + 2, 6);
    m_step(0, 0, 1, 0);
    chk("drop_frame", int'(cur), m_pack());
    repeat (20) @(negedge clk);
    vsync = 1'b1;
    repeat (20) @(negedge clk);
    chk("drop_count", fd_cnt - fd0, 1);

    run = 1'b0;
    fd0 = fd_cnt;
    for (int i = 0; i < 10; i++) begin
      {bl, br, bg, bb} = 4'($urandom_range(0, 15));
      vsync = 1'b0;
      repeat (5) @(negedge clk);
      chk("frozen_busy", int'(busy), 0);
      vsync = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk("frozen_fd", fd_cnt - fd0, 0);
    chk("frozen_out", int'(cur), m_pack());
    run = 1'b1;
    frame(0, 0, 1, 0);
    frame(1, 0, 0, 0);

    fd0 = fd_cnt;
    @(negedge clk);
    {bl, br, bg, bb} = 4'b0110;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_sx", int'(scroll_x), 0);
    chk("abort_sy", int'(scroll_y), 80);
    chk("abort_deg_spd", int'({degree, speed}), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b1;
    m_reset();
    repeat (10) @(negedge clk);
    chk("abort_no_fd", fd_cnt - fd0, 0);
    frame(0, 0, 0, 0);
    chk("post_rst_sx", int'(scroll_x), 0);
    chk("post_rst_sy", int'(scroll_y), 80);

    chk("out_change_outside_commit", bad, 0);
    chk("fd_width", fd_long, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
